// File: rtl/uart_tx_word_packer_if.sv
// Word stream from the matrix-result pipeline into uart_tx_word_packer.
interface uart_tx_word_packer_if #(
   parameter int WIDTH = 16
) ();
   logic             s_valid;
   logic             s_ready;
   logic [WIDTH-1:0] s_data;

   modport master (output s_valid, output s_data, input s_ready);
   modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/uart_tx_word_packer.sv
// Buffers result words in a small FIFO and hands them byte by byte to an 8-bit UART TX.
// Define TX_PACKER_DELIM_EN to append DELIM_BYTE after every ROW_LEN words.
module uart_tx_word_packer #(
   parameter int         WORD_BYTES = 2,
   parameter int         FIFO_DEPTH = 8,
   parameter bit         MSB_FIRST  = 1'b1,
   parameter int         ROW_LEN    = 4,
   parameter logic [7:0] DELIM_BYTE = 8'h0A
) (
   input  logic                        clk,
   input  logic                        rst_n,
   uart_tx_word_packer_if.slave        s,
   output logic                        tx_start,
   output logic [7:0]                  tx_data,
   input  logic                        tx_busy,
   input  logic                        tx_done,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count,
   output logic                        idle
);
   localparam int WW = 8 * WORD_BYTES;
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int BW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
   localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
   localparam logic [BW-1:0] LAST_IDX = BW'(WORD_BYTES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_WAIT_BUSY,
`ifdef TX_PACKER_DELIM_EN
      S_WAIT_DONE,
      S_DELIM
`else
      S_WAIT_DONE
`endif
   } state_t;

   logic [WW-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
   logic [CW-1:0] count_reg, count_next;
   logic          ready_reg;
   logic          push, pop;

   state_t        state_reg;
   logic [WW-1:0] word_reg;
   logic [BW-1:0] byte_idx_reg;
   logic          tx_start_reg;
   logic [7:0]    tx_data_reg;
   logic          idle_reg;
   logic [7:0]    word_bytes [WORD_BYTES];
   logic [7:0]    sel_byte;

`ifdef TX_PACKER_DELIM_EN
   localparam int WCW = (ROW_LEN > 1) ? $clog2(ROW_LEN) : 1;
   localparam logic [WCW-1:0] ROW_LAST = WCW'(ROW_LEN - 1);
   logic [WCW-1:0] word_cnt_reg;
   logic           delim_reg;
`else
   logic unused_cfg;
   assign unused_cfg = ^{DELIM_BYTE, 32'(ROW_LEN)};
`endif

   assign s.s_ready  = ready_reg;
   assign tx_start   = tx_start_reg;
   assign tx_data    = tx_data_reg;
   assign fifo_count = count_reg;
   assign idle       = idle_reg;

   for (genvar gi = 0; gi < WORD_BYTES; gi++) begin : g_lane
      assign word_bytes[gi] = word_reg[gi*8 +: 8];
   end

   always_comb begin
      sel_byte = word_bytes[0];
      for (int i = 0; i < WORD_BYTES; i++) begin
         if (MSB_FIRST ? (int'(byte_idx_reg) == WORD_BYTES - 1 - i) : (int'(byte_idx_reg) == i))
            sel_byte = word_bytes[i];
      end
   end

   assign push = s.s_valid && ready_reg;

   // The head word stays in the FIFO until its last byte is acknowledged.
   always_comb begin
      pop = (state_reg == S_WAIT_DONE) && tx_done && (byte_idx_reg == LAST_IDX);
`ifdef TX_PACKER_DELIM_EN
      if (delim_reg)
         pop = 1'b0;
`endif
   end

   always_comb begin
      count_next = count_reg;
      case ({push, pop})
         2'b10:   count_next = count_reg + 1'b1;
         2'b01:   count_next = count_reg - 1'b1;
         default: count_next = count_reg;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
         ready_reg  <= 1'b0;
      end else begin
         if (push)
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (pop)
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         count_reg <= count_next;
         ready_reg <= (count_next < DEPTH_C);
      end
   end

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr_reg] <= s.s_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= S_IDLE;
         word_reg     <= '0;
         byte_idx_reg <= '0;
         tx_start_reg <= 1'b0;
         tx_data_reg  <= '0;
         idle_reg     <= 1'b1;
`ifdef TX_PACKER_DELIM_EN
         word_cnt_reg <= '0;
         delim_reg    <= 1'b0;
`endif
      end else begin
         idle_reg <= (count_reg == '0) && (state_reg == S_IDLE) && !tx_busy;
         case (state_reg)
            S_IDLE: begin
               if (count_reg != '0) begin
                  word_reg     <= mem[rd_ptr_reg];
                  byte_idx_reg <= '0;
                  state_reg    <= S_LOAD;
               end
            end
            S_LOAD: begin
               tx_data_reg  <= sel_byte;
               tx_start_reg <= 1'b1;
               state_reg    <= S_WAIT_BUSY;
            end
            // tx_start has been high for a cycle here, so a busy seen now is ours.
            S_WAIT_BUSY: begin
               if (tx_busy) begin
                  tx_start_reg <= 1'b0;
                  state_reg    <= S_WAIT_DONE;
               end
            end
            S_WAIT_DONE: begin
               if (tx_done) begin
`ifdef TX_PACKER_DELIM_EN
                  if (delim_reg) begin
                     delim_reg    <= 1'b0;
                     word_cnt_reg <= '0;
                     state_reg    <= S_IDLE;
                  end else if (byte_idx_reg != LAST_IDX) begin
                     byte_idx_reg <= byte_idx_reg + 1'b1;
                     state_reg    <= S_LOAD;
                  end else if (word_cnt_reg == ROW_LAST) begin
                     state_reg <= S_DELIM;
                  end else begin
                     word_cnt_reg <= word_cnt_reg + 1'b1;
                     state_reg    <= S_IDLE;
                  end
`else
                  if (byte_idx_reg != LAST_IDX) begin
                     byte_idx_reg <= byte_idx_reg + 1'b1;
                     state_reg    <= S_LOAD;
                  end else begin
                     state_reg <= S_IDLE;
                  end
`endif
               end
            end
`ifdef TX_PACKER_DELIM_EN
            S_DELIM: begin
               tx_data_reg  <= DELIM_BYTE;
               tx_start_reg <= 1'b1;
               delim_reg    <= 1'b1;
               state_reg    <= S_WAIT_BUSY;
            end
`endif
            default: state_reg <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_uart_tx_word_packer.sv
// Directed bench for uart_tx_word_packer: an MSB-first and an LSB-first instance,
// each driven by a small transmitter model (busy one cycle after start, done ~10 cycles later).
module tb_uart_tx_word_packer;
   logic clk = 1'b0;
   logic rst_n;
   logic model_rst;
   always #5 clk = ~clk;

   uart_tx_word_packer_if #(.WIDTH(16)) s0_if ();
   uart_tx_word_packer_if #(.WIDTH(16)) s1_if ();

   logic       start0, start1;
   logic [7:0] data0, data1;
   logic [3:0] count0, count1;
   logic       idle0, idle1;

   logic       busy_m [2];
   logic       done_m [2];
   logic       pend_m [2];
   logic       stall  [2];
   int         tmr    [2];
   int         hs     [2];
   logic [7:0] cap0 [$];
   logic [7:0] cap1 [$];

   int n_pass, n_checks;
   int base0, base1;
   logic [15:0] exp_w [$];

   uart_tx_word_packer #(.WORD_BYTES(2), .FIFO_DEPTH(8), .MSB_FIRST(1'b1), .ROW_LEN(64), .DELIM_BYTE(8'h0A)) dut_msb (
      .clk(clk), .rst_n(rst_n), .s(s0_if),
      .tx_start(start0), .tx_data(data0), .tx_busy(busy_m[0]), .tx_done(done_m[0]),
      .fifo_count(count0), .idle(idle0));

   uart_tx_word_packer #(.WORD_BYTES(2), .FIFO_DEPTH(8), .MSB_FIRST(1'b0), .ROW_LEN(2), .DELIM_BYTE(8'h0A)) dut_lsb (
      .clk(clk), .rst_n(rst_n), .s(s1_if),
      .tx_start(start1), .tx_data(data1), .tx_busy(busy_m[1]), .tx_done(done_m[1]),
      .fifo_count(count1), .idle(idle1));

   // Transmitter model; it keeps running across a packer reset, like the real UART.
   always @(posedge clk) begin
      if (model_rst) begin
         for (int i = 0; i < 2; i++) begin
            busy_m[i] <= 1'b0; done_m[i] <= 1'b0; pend_m[i] <= 1'b0; tmr[i] <= 0; hs[i] <= 0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            done_m[i] <= 1'b0;
            if (pend_m[i]) begin
               pend_m[i] <= 1'b0; busy_m[i] <= 1'b1; tmr[i] <= 10;
            end else if (busy_m[i]) begin
               if (tmr[i] == 1) begin busy_m[i] <= 1'b0; done_m[i] <= 1'b1; end
               tmr[i] <= tmr[i] - 1;
            end else if (((i == 0) ? start0 : start1) && !stall[i]) begin
               pend_m[i] <= 1'b1;
               hs[i] <= hs[i] + 1;
               if (i == 0) cap0.push_back(data0); else cap1.push_back(data1);
            end
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] cap_at(input int w, input int i);
      if (w == 0) return (i < cap0.size()) ? cap0[i] : 8'hxx;
      return (i < cap1.size()) ? cap1[i] : 8'hxx;
   endfunction

   // Call at #1 after an edge; returns once the word is accepted or the budget runs out.
   task automatic push(input int w, input logic [15:0] d, output bit ok);
      ok = 1'b0;
      if (w == 0) begin s0_if.s_valid = 1'b1; s0_if.s_data = d; end
      else        begin s1_if.s_valid = 1'b1; s1_if.s_data = d; end
      for (int c = 0; c < 400 && !ok; c++) begin
         ok = (w == 0) ? s0_if.s_ready : s1_if.s_ready;
         tick(1);
      end
      s0_if.s_valid = 1'b0;
      s1_if.s_valid = 1'b0;
   endtask

   task automatic wait_bytes(input int w, input int n, input string tag);
      int c = 0;
      while ((((w == 0) ? cap0.size() - base0 : cap1.size() - base1) < n) && c < 2000) begin
         tick(1);
         c++;
      end
      check({tag, "_timeout"}, 32'(c < 2000), 1);
   endtask

`ifdef TX_PACKER_DELIM_EN
   logic [7:0] dexp [10] = '{8'hB2, 8'hA1, 8'hD4, 8'hC3, 8'h0A, 8'hF6, 8'hE5, 8'h18, 8'h07, 8'h0A};
   logic [15:0] dwords [4] = '{16'hA1B2, 16'hC3D4, 16'hE5F6, 16'h0718};
`endif

   initial begin
      bit ok;
      int nok, c;
      logic [15:0] w;
      n_pass = 0; n_checks = 0; base0 = 0; base1 = 0;
      rst_n = 1'b0; model_rst = 1'b1;
      stall[0] = 1'b0; stall[1] = 1'b0;
      s0_if.s_valid = 1'b0; s0_if.s_data = '0;
      s1_if.s_valid = 1'b0; s1_if.s_data = '0;

      // Reset values
      #12;
      check("rst_ready", s0_if.s_ready, 0);
      check("rst_start", start0, 0);
      check("rst_data", data0, 0);
      check("rst_count", count0, 0);
      check("rst_idle", idle0, 1);
      #10 rst_n = 1'b1; model_rst = 1'b0;
      tick(1);
      check("ready_after_rst", s0_if.s_ready, 1);
      check("ready_after_rst_lsb", s1_if.s_ready, 1);

      // Single word, MSB first, with 2-cycle push-to-start latency
      push(0, 16'hA55A, ok);
      check("a55a_push", ok, 1);
      check("a55a_count", count0, 1);
      check("lat_c0", start0, 0);
      tick(1);
      check("lat_c1", start0, 0);
      tick(1);
      check("lat_c2", start0, 1);
      check("lat_data", data0, 8'hA5);
      wait_bytes(0, 2, "a55a");
      check("a55a_busy_idle", idle0, 0);
      tick(20);
      check("a55a_b0", cap_at(0, 0), 8'hA5);
      check("a55a_b1", cap_at(0, 1), 8'h5A);
      check("a55a_handshakes", hs[0], 2);
      check("a55a_idle", idle0, 1);
      check("a55a_count_end", count0, 0);

      // LSB first
      base1 = cap1.size();
      push(1, 16'h1234, ok);
      check("lsb_push", ok, 1);
      wait_bytes(1, 2, "lsb");
      check("lsb_b0", cap_at(1, base1), 8'h34);
      check("lsb_b1", cap_at(1, base1 + 1), 8'h12);
      tick(20);

      // Fill FIFO while transmitter stalls, ninth word waits for the first pop
      base0 = cap0.size();
      stall[0] = 1'b1;
      nok = 0;
      for (int i = 0; i < 8; i++) begin
         push(0, 16'h9000 + 16'(i * 16'h0101), ok);
         nok += int'(ok);
      end
      tick(3);
      check("fill_accepts", nok, 8);
      check("fill_ready_low", s0_if.s_ready, 0);
      check("fill_count", count0, 8);
      check("fill_no_bytes", cap0.size() - base0, 0);
      stall[0] = 1'b0;
      push(0, 16'h9808, ok);
      check("fill_ninth_push", ok, 1);
      check("fill_ninth_after_pop", 32'(cap0.size() - base0 >= 2), 1);
      wait_bytes(0, 18, "fill");
      for (int i = 0; i < 9; i++) begin
         w = 16'h9000 + 16'(i * 16'h0101);
         check($sformatf("fill_w%0d_hi", i), cap_at(0, base0 + 2*i), w[15:8]);
         check($sformatf("fill_w%0d_lo", i), cap_at(0, base0 + 2*i + 1), w[7:0]);
      end
      tick(20);

      // Push coinciding with pop at count 3, 20 random words
      base0 = cap0.size();
      exp_w.delete();
      stall[0] = 1'b1;
      for (int i = 0; i < 3; i++) begin
         w = 16'h5A01 + 16'(i);
         exp_w.push_back(w);
         push(0, w, ok);
      end
      tick(2);
      check("pp_prefill", count0, 3);
      stall[0] = 1'b0;
      for (int k = 0; k < 20; k++) begin
         c = 0;
         while (!(done_m[0] && ((cap0.size() - base0) % 2 == 0)) && c < 400) begin
            tick(1);
            c++;
         end
         check("pp_wait", 32'(c < 400), 1);
         w = 16'($urandom);
         exp_w.push_back(w);
         check("pp_ready", s0_if.s_ready, 1);
         s0_if.s_valid = 1'b1; s0_if.s_data = w;
         tick(1);
         s0_if.s_valid = 1'b0;
         check($sformatf("pp_count_%0d", k), count0, 3);
      end
      wait_bytes(0, 46, "pp");
      for (int i = 0; i < 23; i++) begin
         check($sformatf("pp_w%0d_hi", i), cap_at(0, base0 + 2*i), exp_w[i][15:8]);
         check($sformatf("pp_w%0d_lo", i), cap_at(0, base0 + 2*i + 1), exp_w[i][7:0]);
      end
      tick(20);

      // Reset after the first byte of a word is done
      base0 = cap0.size();
      push(0, 16'hC3D4, ok);
      push(0, 16'h1122, ok);
      wait_bytes(0, 2, "mid");
      check("mid_pre_start", start0, 1);
      check("mid_pre_count", count0, 2);
      #2 rst_n = 1'b0;
      #1;
      check("mid_start_async", start0, 0);
      check("mid_count", count0, 0);
      check("mid_ready", s0_if.s_ready, 0);
      check("mid_idle", idle0, 1);
      #2 rst_n = 1'b1;
      tick(1);
      c = 0;
      while ((busy_m[0] || pend_m[0] || done_m[0]) && c < 50) begin
         tick(1);
         c++;
      end
      check("mid_model_quiet", 32'(c < 50), 1);
      tick(2);
      base0 = cap0.size();
      push(0, 16'hBEEF, ok);
      check("beef_push", ok, 1);
      wait_bytes(0, 2, "beef");
      check("beef_b0", cap_at(0, base0), 8'hBE);
      check("beef_b1", cap_at(0, base0 + 1), 8'hEF);
      tick(40);
      check("beef_discarded_rest", cap0.size() - base0, 2);

`ifdef TX_PACKER_DELIM_EN
      // Row delimiter on the LSB instance (ROW_LEN=2)
      base1 = cap1.size();
      for (int i = 0; i < 4; i++) push(1, dwords[i], ok);
      wait_bytes(1, 10, "delim");
      for (int i = 0; i < 10; i++)
         check($sformatf("delim_b%0d", i), cap_at(1, base1 + i), dexp[i]);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/uart_tx_word_packer.md
Name: uart_tx_word_packer

Overview:
- Upstream feeder for the 8-bit UART transmitter. It accepts matrix-result words over a valid/ready stream and buffers them in a small FIFO.
- Each word is split into bytes, and each byte is handed to the transmitter with a start/busy/done handshake.
- Sits between the matrix-multiply result pipeline and the UART TX; runs on the same clock as the transmitter.

Parameters:
- WORD_BYTES, 2, bytes per input word (1..4); s_data width = 8*WORD_BYTES.
- FIFO_DEPTH, 8, word FIFO entries; power of two, >= 2.
- MSB_FIRST, 1, 1 = most-significant byte sent first, 0 = least-significant first.
- ROW_LEN, 4, words per row (used only by the optional feature).
- DELIM_BYTE, 8'h0A, delimiter byte (used only by the optional feature).

Ports:
- clk  in  1  clock, same as transmitter clock.
- rst_n  in  1  asynchronous active-low reset.
- s_valid  in  1  input word valid.
- s_ready  out  1  FIFO can accept a word.
- s_data  in  8*WORD_BYTES  input word.
- tx_start  out  1  start request to transmitter.
- tx_data  out  8  byte presented to transmitter.
- tx_busy  in  1  transmitter busy.
- tx_done  in  1  transmitter one-cycle done pulse.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  words held in FIFO.
- idle  out  1  FIFO empty, FSM in S_IDLE, tx_busy low.

Behaviour:
- Reset (async, rst_n=0) values:
  - s_ready=0 while rst_n low, 1 from the first clock edge after release.
  - tx_start=0, tx_data=0, fifo_count=0, idle=1.
  - FIFO pointers and byte index zeroed; FSM=S_IDLE.
- FIFO:
  - Push when s_valid && s_ready; s_ready = (count < FIFO_DEPTH).
  - Pop occurs when the last byte of the head word completes.
  - Push and pop in the same cycle while full is allowed only because s_ready is already low when full, so no push occurs.
  - Push and pop in the same cycle while not full: count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - Push-to-first-tx_start latency from an empty FIFO: 2 cycles.
- FSM states:
  - S_IDLE: if FIFO non-empty, latch head word into shift register; byte_idx=0; go S_LOAD.
  - S_LOAD: drive tx_data = selected byte; tx_start=1; go S_WAIT_BUSY.
  - S_WAIT_BUSY: hold tx_start=1 and tx_data stable until tx_busy=1. Then tx_start=0; go S_WAIT_DONE.
  - S_WAIT_DONE: wait for tx_done=1.
    - If byte_idx < WORD_BYTES-1: byte_idx++; go S_LOAD.
    - Else: pop FIFO; go S_IDLE. Back-to-back words re-enter S_LOAD on the next cycle via S_IDLE.
- Byte select:
  - MSB_FIRST=1: byte (WORD_BYTES-1-byte_idx).
  - MSB_FIRST=0: byte byte_idx.
- tx_done outside S_WAIT_DONE is ignored.
- tx_busy already high in S_LOAD (stale transfer) is treated as an acknowledgement only once tx_start has been driven for at least one cycle.
- Word is latched at S_IDLE exit; later FIFO pushes never alter in-flight bytes.
- A reset during a transfer aborts immediately: FIFO contents are discarded and tx_start drops asynchronously. The downstream transmitter finishes its current byte independently.
- idle is registered and updates one cycle after the conditions change.

Optional Feature:
- Macro: TX_PACKER_DELIM_EN.
- Defined:
  - A word counter counts popped words.
  - After every ROW_LEN-th word, the FSM enters S_DELIM, which sends DELIM_BYTE via the same S_LOAD/S_WAIT_BUSY/S_WAIT_DONE handshake, then returns to S_IDLE.
  - The word counter wraps to 0 after the delimiter is sent and resets to 0 on rst_n.
- Undefined: no counter, no S_DELIM; the byte stream is only word bytes.

Test Plan:
- Push 16'hA55A (MSB_FIRST=1) with a transmitter model (busy 1 cycle after start, done after 10 cycles) -> tx_data 8'hA5 then 8'h5A; exactly two tx_start handshakes; idle=1 afterwards.
- Push 9 words back-to-back with FIFO_DEPTH=8 while transmitter stalled -> s_ready low after 8th accept; fifo_count=8; 9th word accepted once first word pops; output order preserved.
- MSB_FIRST=0, push 16'h1234 -> bytes 8'h34 then 8'h12.
- Simultaneous push and pop with count=3 -> count stays 3; no word lost or duplicated across 20 random words.
- Assert rst_n=0 mid-word (after first byte done) -> tx_start=0 immediately; fifo_count=0; after release, the next pushed word 16'hBEEF is sent as BE, EF.
- With TX_PACKER_DELIM_EN, ROW_LEN=2, push 4 words -> byte stream w0h w0l w1h w1l 0A w2h w2l w3h w3l 0A.
